// File: rtl/program_loader.sv
// Program memory loader: waits out memory self-init, then streams host bytes to addresses 0.. over valid/ready.
// Optional read-back verify of every write when PROGRAM_LOADER_VERIFY_EN is defined.
module program_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              wen_o,
    output logic [AW-1:0]     waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              ren_o,
    output logic [AW-1:0]     raddr_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [AW:0]       count_o,
    output logic              err_o,
    output logic [2:0]        state_o
);

    // Handshake: a byte transfers on any rising clk_i edge where in_valid_i && in_ready_o;
    // in_ready_o depends only on the state, never combinationally on in_valid_i.

    typedef enum logic [2:0] {
        S_HOLD  = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_VRD   = 3'd5,
        S_VCHK  = 3'd6
    } state_t;

    localparam logic [AW:0]   HOLD_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [AW:0]         hold_cnt_q;
    logic [AW-1:0]       addr_q;
    logic [AW-1:0]       waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                last_q;
    logic [AW:0]         count_q;
    logic                accept;
    logic                start_clr;
    logic                decide;
    logic                end_sess;

    assign end_sess = last_q || (addr_q == ADDR_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        wen_o      = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        accept     = 1'b0;
        start_clr  = 1'b0;
        decide     = 1'b0;
        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (start_i) begin
                    start_clr = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (in_valid_i) begin
                    accept  = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wen_o  = 1'b1;
                busy_o = 1'b1;
`ifdef PROGRAM_LOADER_VERIFY_EN
                state_d = S_VRD;
`else
                decide  = 1'b1;
                state_d = end_sess ? S_DONE : S_LOAD;
`endif
            end
`ifdef PROGRAM_LOADER_VERIFY_EN
            S_VRD: begin
                busy_o  = 1'b1;
                state_d = S_VCHK;
            end
            S_VCHK: begin
                busy_o  = 1'b1;
                decide  = 1'b1;
                state_d = end_sess ? S_DONE : S_LOAD;
            end
`endif
            S_DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    start_clr = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    // Memory ignores writes while it self-initializes, so HOLD just counts DEPTH cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_cnt_q <= '0;
        end else if (state_q == S_HOLD) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (start_clr) begin
                addr_q  <= '0;
                count_q <= '0;
            end
            // Write port registers load only on acceptance so they hold outside WRITE.
            if (accept) begin
                waddr_q <= addr_q;
                wdata_q <= in_data_i;
                last_q  <= in_last_i;
            end
            if (state_q == S_WRITE) begin
                count_q <= count_q + 1'b1;
            end
            if (decide && !end_sess) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

`ifdef PROGRAM_LOADER_VERIFY_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (start_clr) begin
            err_q <= 1'b0;
        end else if (state_q == S_VCHK && rdata_i != wdata_q) begin
            err_q <= 1'b1;
        end
    end

    assign ren_o   = (state_q == S_VRD);
    assign raddr_o = addr_q;
    assign err_o   = err_q;
`else
    logic unused_rdata;

    assign unused_rdata = ^rdata_i;
    assign ren_o        = 1'b0;
    assign raddr_o      = '0;
    assign err_o        = 1'b0;
`endif

    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign count_o = count_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: write-port scoreboard plus per-scenario timing and status checks.
module tb_program_loader;

    localparam int DEPTH    = 16;
    localparam int AW       = 4;
`ifdef PROGRAM_LOADER_VERIFY_EN
    localparam int BYTE_CYC = 4;
`else
    localparam int BYTE_CYC = 2;
`endif
    localparam logic [2:0] ST_HOLD = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic          clk;
    logic          rst_i;
    logic          start_i;
    logic          in_valid_i;
    logic [7:0]    in_data_i;
    logic          in_last_i;
    logic          in_ready_o;
    logic          wen_o;
    logic [AW-1:0] waddr_o;
    logic [7:0]    wdata_o;
    logic          ren_o;
    logic [AW-1:0] raddr_o;
    logic [7:0]    rdata_i;
    logic          busy_o;
    logic          done_o;
    logic [AW:0]   count_o;
    logic          err_o;
    logic [2:0]    state_o;

    int checks   = 0;
    int failures = 0;
    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] exp_w;
    logic [7:0]    mem [DEPTH];

    program_loader #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_last_i(in_last_i),
        .in_ready_o(in_ready_o), .wen_o(wen_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .ren_o(ren_o), .raddr_o(raddr_o), .rdata_i(rdata_i),
        .busy_o(busy_o), .done_o(done_o), .count_o(count_o), .err_o(err_o),
        .state_o(state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; address 1 reads back corrupted as 0xFF.
    always @(posedge clk) begin
        if (wen_o === 1'b1) mem[waddr_o] <= wdata_o;
        if (ren_o === 1'b1) rdata_i <= (raddr_o == 4'd1) ? 8'hFF : mem[raddr_o];
    end

    // Scoreboard: every write pulse must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (rst_i === 1'b1 && wen_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h", waddr_o, wdata_o);
            end else begin
                exp_w = exp_q.pop_front();
                if ({waddr_o, wdata_o} !== exp_w) begin
                    failures++;
                    $display("FAIL write_beat got addr=%0d data=%h exp addr=%0d data=%h",
                             waddr_o, wdata_o, exp_w[AW+7:8], exp_w[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // Driver tasks (called at a negedge, return at the negedge after acceptance)
    task automatic send_byte(input logic [7:0] d, input logic l, input logic [AW-1:0] a);
        int w;
        w = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        while (in_ready_o !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout data=%h ready=%b exp 1", d, in_ready_o);
        end else begin
            exp_q.push_back({a, d});
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready_o, wen_o, ren_o, busy_o, done_o, err_o, count_o, waddr_o, wdata_o, raddr_o} !== '0
            || state_o !== ST_HOLD) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b wen=%b busy=%b done=%b cnt=%0d st=%0d exp all 0",
                     in_ready_o, wen_o, busy_o, done_o, count_o, state_o);
        end
        rst_i = 1'b1;
        for (int c = 1; c <= DEPTH; c++) begin
            if (c == 5) start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            if (c == DEPTH - 1) begin
                checks++;
                if (state_o !== ST_HOLD || in_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL hold_length st=%0d rdy=%b exp st=0 rdy=0", state_o, in_ready_o);
                end
            end
        end
        checks++;
        if (state_o !== ST_IDLE) begin
            failures++;
            $display("FAIL idle_reached st=%0d exp %0d", state_o, ST_IDLE);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready_o !== 1'b0 || state_o !== ST_IDLE || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL start_in_hold_ignored rdy=%b st=%0d busy=%b exp 0/1/0", in_ready_o, state_o, busy_o);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [3];
        bytes[0] = 8'h45; bytes[1] = 8'h80; bytes[2] = 8'h01;
        pulse_start();
        checks++;
        if (in_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL start_ready rdy=%b busy=%b exp 1/1", in_ready_o, busy_o);
        end
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i], i == 2, AW'(i));
            checks++;
            if (wen_o !== 1'b1) begin
                failures++;
                $display("FAIL wen_latency byte=%0d wen=%b exp 1", i, wen_o);
            end
            repeat (BYTE_CYC - 1) @(negedge clk);
            checks++;
            if (in_ready_o !== (i != 2) || done_o !== (i == 2)) begin
                failures++;
                $display("FAIL byte_turnaround byte=%0d rdy=%b done=%b exp %b/%b",
                         i, in_ready_o, done_o, i != 2, i == 2);
            end
        end
        checks++;
        if (count_o !== 5'd3 || done_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_status cnt=%0d done=%b busy=%b err=%b exp 3/1/0/0",
                     count_o, done_o, busy_o, err_o);
        end
    endtask

    task automatic test_stall();
        pulse_start();
        send_byte(8'h33, 1'b0, 4'd0);
        repeat (BYTE_CYC - 1) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            checks++;
            if (in_ready_o !== 1'b1 || wen_o !== 1'b0 || state_o !== ST_LOAD || count_o !== 5'd1) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d rdy=%b wen=%b st=%0d cnt=%0d exp 1/0/2/1",
                         c, in_ready_o, wen_o, state_o, count_o);
            end
        end
        send_byte(8'hA5, 1'b1, 4'd1);
        repeat (BYTE_CYC - 1) @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || count_o !== 5'd2) begin
            failures++;
            $display("FAIL stall_finish done=%b cnt=%0d exp 1/2", done_o, count_o);
        end
    endtask

    task automatic test_full();
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'h10 + 8'(i), 1'b0, AW'(i));
            repeat (BYTE_CYC - 1) @(negedge clk);
            if (i < DEPTH - 1) begin
                checks++;
                if (in_ready_o !== 1'b1 || done_o !== 1'b0) begin
                    failures++;
                    $display("FAIL full_midstream byte=%0d rdy=%b done=%b exp 1/0", i, in_ready_o, done_o);
                end
            end
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || count_o !== 5'd16) begin
            failures++;
            $display("FAIL full_wrap_end done=%b busy=%b cnt=%0d exp 1/0/16", done_o, busy_o, count_o);
        end
        in_valid_i = 1'b1;
        in_data_i  = 8'hEE;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready_o !== 1'b0 || state_o !== ST_DONE) begin
                failures++;
                $display("FAIL extra_byte_ignored rdy=%b st=%0d exp 0/%0d", in_ready_o, state_o, ST_DONE);
            end
        end
        in_valid_i = 1'b0;
    endtask

`ifdef PROGRAM_LOADER_VERIFY_EN
    task automatic test_verify();
        logic [7:0] bytes [3];
        bytes[0] = 8'h45; bytes[1] = 8'h80; bytes[2] = 8'h01;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i], i == 2, AW'(i));
            repeat (BYTE_CYC - 1) @(negedge clk);
            checks++;
            if (err_o !== (i >= 1)) begin
                failures++;
                $display("FAIL verify_err byte=%0d err=%b exp %b", i, err_o, i >= 1);
            end
        end
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b1) begin
            failures++;
            $display("FAIL verify_sticky done=%b err=%b exp 1/1", done_o, err_o);
        end
        pulse_start();
        checks++;
        if (err_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL verify_clear err=%b done=%b exp 0/0", err_o, done_o);
        end
        send_byte(8'h5A, 1'b1, 4'd0);
        repeat (BYTE_CYC - 1) @(negedge clk);
        checks++;
        if (err_o !== 1'b0 || done_o !== 1'b1) begin
            failures++;
            $display("FAIL verify_clean err=%b done=%b exp 0/1", err_o, done_o);
        end
    endtask
`endif

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'h11, 1'b0, 4'd0);
        repeat (BYTE_CYC - 1) @(negedge clk);
        send_byte(8'h22, 1'b0, 4'd1);
        repeat (BYTE_CYC - 1) @(negedge clk);
        send_byte(8'h33, 1'b0, 4'd2);
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({in_ready_o, wen_o, ren_o, busy_o, done_o, err_o, count_o, waddr_o, wdata_o} !== '0
            || state_o !== ST_HOLD) begin
            failures++;
            $display("FAIL reset_mid wen=%b busy=%b cnt=%0d waddr=%0d wdata=%h st=%0d exp all 0",
                     wen_o, busy_o, count_o, waddr_o, wdata_o, state_o);
        end
        @(negedge clk);
        rst_i = 1'b1;
        repeat (DEPTH) @(negedge clk);
        checks++;
        if (state_o !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_mid_hold st=%0d exp %0d", state_o, ST_IDLE);
        end
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'hC0 + 8'(i), i == DEPTH - 1, AW'(i));
            repeat (BYTE_CYC - 1) @(negedge clk);
        end
        checks++;
        if (done_o !== 1'b1 || count_o !== 5'd16 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reload_status done=%b cnt=%0d busy=%b exp 1/16/0", done_o, count_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full();
`ifdef PROGRAM_LOADER_VERIFY_EN
        test_verify();
`endif
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes pending=%0d exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
